// File: rtl/bram_frame_addr_gen.sv
// Ping-pong BRAM write address generator: turns accepted samples into delayed
// single-cycle writes, fills two banks in turn and stalls while the next bank is still full.
module bram_frame_addr_gen #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned FRAME_LEN = 1024,
   parameter int unsigned WAIT_CYC  = 2,
   parameter int unsigned ADDR_STEP = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              stop,
   input  logic              hab,
   input  logic              valid,
   input  logic              rd_done,
   input  logic              rd_bank,
   output logic              we,
   output logic [ADDR_W-1:0] addr,
   output logic              bank,
   output logic              frame_done,
   output logic              busy,
   output logic              stall,
   output logic              overrun
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_SETTLE = 3'd2;
   localparam logic [2:0] S_WRITE  = 3'd3;
   localparam logic [2:0] S_STALL  = 3'd4;

   localparam int unsigned IDX_W       = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned CNT_W       = (WAIT_CYC > 2) ? $clog2(WAIT_CYC) : 1;
   localparam int unsigned SETTLE_INIT = (WAIT_CYC > 0) ? WAIT_CYC - 1 : 0;
   localparam longint unsigned SPAN    = longint'(2) * longint'(FRAME_LEN) * longint'(ADDR_STEP);

   if (FRAME_LEN < 2 || ADDR_STEP < 1 ||
       (ADDR_W < 64 && SPAN > (64'd1 << ADDR_W))) begin : g_param_err
      $error("bram_frame_addr_gen: 2*FRAME_LEN*ADDR_STEP must fit in ADDR_W bits");
   end

   logic [2:0]        state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [1:0]        full, full_n;
   logic              stop_pend, stop_pend_n;
   logic              bank_n, ovr_n, we_n, fd_n;
   logic [ADDR_W-1:0] addr_n, lin_addr;
   logic              sample, last;

   assign sample   = valid && !hab;
   assign last     = (idx == IDX_W'(FRAME_LEN - 1));
   assign lin_addr = (ADDR_W'(bank) * ADDR_W'(FRAME_LEN) + ADDR_W'(idx)) * ADDR_W'(ADDR_STEP);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      idx_n       = idx;
      full_n      = full;
      bank_n      = bank;
      stop_pend_n = stop_pend;
      ovr_n       = overrun;
      we_n        = 1'b0;
      fd_n        = 1'b0;
      addr_n      = addr;
      if (rd_done) full_n[rd_bank] = 1'b0;
      case (state)
         S_IDLE: begin
            if (arm && !stop) begin
               state_n = S_RUN;
               ovr_n   = 1'b0;
               idx_n   = '0;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_n = S_IDLE;
               idx_n   = '0;
            end else if (sample) begin
               stop_pend_n = 1'b0;
               if (WAIT_CYC == 0) begin
                  state_n = S_WRITE;
                  we_n    = 1'b1;
                  addr_n  = lin_addr;
                  fd_n    = last;
               end else begin
                  state_n = S_SETTLE;
                  cnt_n   = CNT_W'(SETTLE_INIT);
               end
            end
         end
         S_SETTLE: begin
            if (sample) ovr_n = 1'b1;
            if (stop) stop_pend_n = 1'b1;
            if (cnt == '0) begin
               state_n = S_WRITE;
               we_n    = 1'b1;
               addr_n  = lin_addr;
               fd_n    = last;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         S_WRITE: begin
            if (sample) ovr_n = 1'b1;
            // the full set follows the rd_done clear so a same-edge release of the
            // bank just completed cannot erase fresh data; the stall check sees both
            if (last) begin
               full_n[bank] = 1'b1;
               bank_n       = ~bank;
               idx_n        = '0;
            end else begin
               idx_n = idx + IDX_W'(1);
            end
            if (stop || stop_pend) begin
               state_n     = S_IDLE;
               idx_n       = '0;
               stop_pend_n = 1'b0;
            end else if (last && full_n[~bank]) begin
               state_n = S_STALL;
            end else begin
               state_n = S_RUN;
            end
         end
         S_STALL: begin
            if (sample) ovr_n = 1'b1;
            if (stop) begin
               state_n = S_IDLE;
               idx_n   = '0;
            end else if (!full[bank]) begin
               state_n = S_RUN;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         idx        <= '0;
         full       <= '0;
         stop_pend  <= 1'b0;
         we         <= 1'b0;
         addr       <= '0;
         bank       <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         stall      <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         idx        <= idx_n;
         full       <= full_n;
         stop_pend  <= stop_pend_n;
         we         <= we_n;
         addr       <= addr_n;
         bank       <= bank_n;
         frame_done <= fd_n;
         busy       <= (state_n != S_IDLE);
         stall      <= (state_n == S_STALL);
         overrun    <= ovr_n;
      end
   end

endmodule

// File: doc/bram_frame_addr_gen.md
BRAM_FRAME_ADDR_GEN -- requirements
Module: bram_frame_addr_gen

Interface
- Parameters, one per line: name, default, meaning.
- Ports, one per line: name, direction, width, meaning.

REQ-001 SHALL have parameter ADDR_W, 32, address output width.
REQ-002 SHALL have parameter FRAME_LEN, 1024, samples per frame (>=2).
REQ-003 SHALL have parameter WAIT_CYC, 2, settle cycles between sample acceptance and write (>=0).
REQ-004 SHALL have parameter ADDR_STEP, 1, address increment per sample (>=1).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port arm, input, 1, level; starts capture from IDLE.
REQ-008 SHALL have port stop, input, 1, level; ends capture.
REQ-009 SHALL have port hab, input, 1, inhibit; while 1, valid is ignored.
REQ-010 SHALL have port valid, input, 1, one sample available this cycle.
REQ-011 SHALL have port rd_done, input, 1, pulse; consumer releases bank rd_bank.
REQ-012 SHALL have port rd_bank, input, 1, bank released by rd_done.
REQ-013 SHALL have port we, output, 1, BRAM write enable, one cycle per sample.
REQ-014 SHALL have port addr, output, ADDR_W, BRAM write address; valid when we=1.
REQ-015 SHALL have port bank, output, 1, bank currently filling.
REQ-016 SHALL have port frame_done, output, 1, one-cycle pulse on last write of a frame.
REQ-017 SHALL have port busy, output, 1, 1 when state is not IDLE.
REQ-018 SHALL have port stall, output, 1, 1 in state STALL.
REQ-019 SHALL have port overrun, output, 1, sticky flag for a dropped sample.

Function
REQ-020 SHALL implement states IDLE, RUN, SETTLE, WRITE, STALL; all outputs registered.
REQ-021 SHALL move IDLE->RUN on arm=1 and stop=0, clearing overrun and the sample index idx; arm with stop=1 stays IDLE.
REQ-022 SHALL accept a sample in RUN when valid=1 and hab=0, going to SETTLE (WAIT_CYC>0) or directly to WRITE (WAIT_CYC=0).
REQ-023 SHALL remain in SETTLE exactly WAIT_CYC cycles, then spend one cycle in WRITE; for a valid sampled in cycle t, we=1 in cycle t+WAIT_CYC+1.
REQ-024 SHALL drive addr = (bank*FRAME_LEN + idx)*ADDR_STEP, truncated to ADDR_W; we=0 and addr held at the last value outside WRITE.
REQ-025 SHALL increment idx after each write; when idx=FRAME_LEN-1: pulse frame_done with that write, set full[bank], toggle bank, set idx=0.
REQ-026 SHALL, after a frame completes, enter STALL if the new bank is full, else RUN; in STALL it returns to RUN the cycle after full[bank] clears.
REQ-027 SHALL clear full[rd_bank] on rd_done=1; if the clear and the entry check for the same bank coincide, the clear wins and STALL is not entered.
REQ-028 SHALL drop a sample that arrives with valid=1 and hab=0 in SETTLE, WRITE or STALL, with no write, and set overrun=1 until the next arm from IDLE or rst.
REQ-029 SHALL ignore valid when hab=1 in every state, with no overrun.
REQ-030 SHALL, on stop=1 in RUN or STALL, go to IDLE next cycle; in SETTLE/WRITE it completes the pending write first, then goes to IDLE; idx clears, bank/full keep their values.
REQ-031 SHALL be usable only where 2*FRAME_LEN*ADDR_STEP <= 2^ADDR_W; the simulation parameter check errors otherwise.

Reset
REQ-032 SHALL, on rst=1 at any clock edge and in any state, set state=IDLE, we=0, addr=0, bank=0, frame_done=0, busy=0, stall=0, overrun=0, idx=0, full=00, settle counter=0; any pending write is discarded.

Verification (ADDR_W=8, FRAME_LEN=4, WAIT_CYC=2, ADDR_STEP=1)
REQ-033 SHALL cover reset: rst held 2 cycles with random inputs -> all outputs 0 in the cycle after release.
REQ-034 SHALL cover one frame: arm, 4 valids 5 cycles apart -> we 3 cycles after each valid at addr 0,1,2,3; frame_done with addr 3; then bank=1, full=01.
REQ-035 SHALL cover ping-pong and stall: continue 4 valids -> addr 4..7; no rd_done -> stall=1, next valid sets overrun=1 with no we; rd_done with rd_bank=0 -> RUN, next write at addr 0.
REQ-036 SHALL cover inhibit and overlap: valid with hab=1 -> no we, overrun stays 0; second valid 1 cycle after an accepted one -> one write only, overrun=1.
REQ-037 SHALL cover stop/reset mid-operation: stop in SETTLE -> write completes, then busy=0; rst in SETTLE -> no we, addr=0.
